// File: rtl/rv32_pkg.sv
// Shared types for the rv32 multi-cycle control path: controller states, PC/writeback
// selects and the decoder output bundle.
package rv32_pkg;

  typedef enum logic [2:0] {
    RESET, FETCH, IWAIT, DECODE, EXECUTE, MREQ, MWAIT, TRAP
  } ctrl_state_e;

  typedef enum logic [1:0] {PC_PLUS4, PC_BRANCH, PC_JALR} pc_sel_e;
  typedef enum logic [1:0] {WB_ALU, WB_MEM, WB_PC4} wb_sel_e;

  localparam logic [6:0] OPC_JALR = 7'b1100111;

  typedef struct packed {
    logic [6:0] opcode;
    logic [4:0] rd;
    logic [2:0] branch_op;
    logic       branch;
    logic       jump;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
  } decoded_instr_t;

endpackage

// File: rtl/multicycle_ctrl_wait_timer.sv
// Saturating wait counter shared by all memory-wait states; flags the last allowed cycle.
module wait_timer #(
  parameter int W      = 8,
  parameter int CYCLES = 16
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam logic [W-1:0] LAST = W'(CYCLES - 1);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                     cnt_q <= '0;
    else if (clr_i)                  cnt_q <= '0;
    else if (en_i && cnt_q != '1)    cnt_q <= cnt_q + 1'b1;
  end

  // CYCLES==0 disables the timeout entirely
  assign expired_o = (CYCLES != 0) && en_i && (cnt_q == LAST);

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle fetch/decode/execute/memory sequencer for the rv32 core; drives memory
// handshakes and the PC/IR/regfile write strobes.
module multicycle_ctrl
  import rv32_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int TIMEOUT_W      = 8
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  decoded_instr_t decoded_i,
  input  logic           illegal_i,
  input  logic           branch_taken_i,
  output logic           imem_req_o,
  input  logic           imem_gnt_i,
  input  logic           imem_rvalid_i,
  output logic           ir_we_o,
  output logic           dmem_req_o,
  output logic           dmem_we_o,
  input  logic           dmem_gnt_i,
  input  logic           dmem_rvalid_i,
  output logic           pc_we_o,
  output pc_sel_e        pc_sel_o,
  output logic           rf_we_o,
  output wb_sel_e        wb_sel_o,
  output ctrl_state_e    state_o,
  output logic           retire_o,
  output logic           trap_o
);

  ctrl_state_e state_q, state_d;
  logic        rf_we_raw, mem_done, expired, wait_st;
  logic        unused_branch_op;

  assign unused_branch_op = ^decoded_i.branch_op;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= RESET;
    else         state_q <= state_d;
  end

  assign wait_st = (state_q == FETCH) || (state_q == IWAIT) ||
                   (state_q == MREQ)  || (state_q == MWAIT);

  // any state change restarts the count, so each wait state begins at zero
  wait_timer #(.W(TIMEOUT_W), .CYCLES(TIMEOUT_CYCLES)) u_timer (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .clr_i     (state_d != state_q),
    .en_i      (wait_st),
    .expired_o (expired)
  );

  always_comb begin
    state_d    = state_q;
    imem_req_o = 1'b0;
    ir_we_o    = 1'b0;
    dmem_req_o = 1'b0;
    dmem_we_o  = 1'b0;
    pc_we_o    = 1'b0;
    pc_sel_o   = PC_PLUS4;
    rf_we_raw  = 1'b0;
    wb_sel_o   = WB_ALU;
    retire_o   = 1'b0;
    trap_o     = 1'b0;
    mem_done   = 1'b0;
    case (state_q)
      RESET: state_d = FETCH;
      FETCH: begin
        imem_req_o = 1'b1;
        if (imem_gnt_i) begin
          if (imem_rvalid_i) begin
            ir_we_o = 1'b1;
            state_d = DECODE;
          end else state_d = IWAIT;
        end else if (expired) state_d = TRAP;
      end
      IWAIT: begin
        if (imem_rvalid_i) begin
          ir_we_o = 1'b1;
          state_d = DECODE;
        end else if (expired) state_d = TRAP;
      end
      DECODE: state_d = illegal_i ? TRAP : EXECUTE;
      EXECUTE: begin
        if (decoded_i.branch) begin
          pc_we_o  = 1'b1;
          pc_sel_o = branch_taken_i ? PC_BRANCH : PC_PLUS4;
          retire_o = 1'b1;
          state_d  = FETCH;
        end else if (decoded_i.jump) begin
          rf_we_raw = 1'b1;
          wb_sel_o  = WB_PC4;
          pc_we_o   = 1'b1;
          pc_sel_o  = (decoded_i.opcode == OPC_JALR) ? PC_JALR : PC_BRANCH;
          retire_o  = 1'b1;
          state_d   = FETCH;
        end else if (decoded_i.mem_read || decoded_i.mem_write) begin
          state_d = MREQ;
        end else begin
          rf_we_raw = decoded_i.reg_write;
          pc_we_o   = 1'b1;
          retire_o  = 1'b1;
          state_d   = FETCH;
        end
      end
      MREQ: begin
        dmem_req_o = 1'b1;
        dmem_we_o  = decoded_i.mem_write;
        if (dmem_gnt_i) begin
          if (dmem_rvalid_i) mem_done = 1'b1;
          else               state_d  = MWAIT;
        end else if (expired) state_d = TRAP;
      end
      MWAIT: begin
        if (dmem_rvalid_i) mem_done = 1'b1;
        else if (expired)  state_d  = TRAP;
      end
      TRAP:    trap_o  = 1'b1;
      default: state_d = RESET;
    endcase
    if (mem_done) begin
      rf_we_raw = decoded_i.mem_read;
      wb_sel_o  = decoded_i.mem_read ? WB_MEM : WB_ALU;
      pc_we_o   = 1'b1;
      retire_o  = 1'b1;
      state_d   = FETCH;
    end
  end

  // x0 is hardwired zero, never write it
  assign rf_we_o = rf_we_raw && (decoded_i.rd != 5'd0);
  assign state_o = state_q;

endmodule
